// File: rtl/onewire_slot_engine.sv
// ---------------------------------------------------------------------------
// onewire_slot_engine
//
// Bit/byte level 1-Wire bus master. Accepts byte commands over a valid/ready
// handshake and produces reset/presence, write-slot and read-slot timing on
// an open-drain data line. The line is only ever driven as a pull-low enable;
// the top level turns line_pull_low into the actual tristate.
//
// Optional feature (compile-time macro ONEWIRE_CRC8_EN):
//   adds crc_clear / crc and a Dallas/Maxim CRC-8 over every bit written or
//   read. Without the macro neither the ports nor the logic exist.
//
// Ports:
//   clock         system clock (100 MHz nominal, timing params in clocks)
//   reset         synchronous, active-high reset
//   cmd_valid     command request
//   cmd[1:0]      00 bus reset, 01 write byte, 10 read byte, 11 no-op
//   tx_byte[7:0]  byte to write, latched on accept
//   cmd_ready     idle and able to accept a command
//   done          one-cycle pulse when a command completes
//   rx_byte[7:0]  last byte read, LSB received first
//   presence      result of the last bus reset (1 = slave answered)
//   crc_clear     (ONEWIRE_CRC8_EN) clear crc, honoured only while cmd_ready
//   crc[7:0]      (ONEWIRE_CRC8_EN) running CRC-8
//   line_in       data line level at the pad (asynchronous)
//   line_pull_low 1 = drive data line low, 0 = release (registered)
// ---------------------------------------------------------------------------
module onewire_slot_engine #(
   parameter int unsigned T_RSTL = 48000,
   parameter int unsigned T_PDS  = 7000,
   parameter int unsigned T_RSTH = 48000,
   parameter int unsigned T_SLOT = 6500,
   parameter int unsigned T_LOW1 = 600,
   parameter int unsigned T_LOW0 = 6000,
   parameter int unsigned T_RDS  = 1500,
   parameter int unsigned T_REC  = 200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] cmd,
   input  logic [7:0] tx_byte,
   output logic       cmd_ready,
   output logic       done,
   output logic [7:0] rx_byte,
   output logic       presence,
`ifdef ONEWIRE_CRC8_EN
   input  logic       crc_clear,
   output logic [7:0] crc,
`endif
   input  logic       line_in,
   output logic       line_pull_low
);

   localparam logic [1:0] CMD_RST = 2'b00;
   localparam logic [1:0] CMD_WR  = 2'b01;
   localparam logic [1:0] CMD_RD  = 2'b10;

   // Terminal counts: the counter starts at 0 on the first cycle of a phase,
   // so a phase of N cycles ends on the edge where cnt == N-1.
   localparam logic [15:0] RSTL_END = 16'(T_RSTL - 1);
   localparam logic [15:0] RSTH_END = 16'(T_RSTH - 1);
   localparam logic [15:0] PDS_AT   = 16'(T_PDS);
   localparam logic [15:0] SLOT_END = 16'(T_SLOT - 1);
   localparam logic [15:0] LOW1_END = 16'(T_LOW1 - 1);
   localparam logic [15:0] LOW0_END = 16'(T_LOW0 - 1);
   localparam logic [15:0] RDS_AT   = 16'(T_RDS);
   localparam logic [15:0] REC_END  = 16'(T_REC - 1);

   typedef enum logic [2:0] {
      IDLE,
      RST_LOW,
      RST_HIGH,
      SLOT_LOW,
      SLOT_HIGH,
      SLOT_REC,
      FINISH
   } state_t;

   state_t      state;
   logic [15:0] cnt;       // phase / slot timer
   logic [2:0]  bit_idx;
   logic [1:0]  cmd_q;
   logic [7:0]  shreg;     // write data (indexed) or read data (shifted in)
   logic [1:0]  sync;      // line_in synchroniser, sync[1] is the usable value
   logic        line_sync;

   logic        accept;
   logic        sample_rd;
   logic [15:0] low_end;

   assign line_sync = sync[1];
   assign accept    = cmd_valid & cmd_ready;

   // Read sample point is measured from slot start, so it may land in either
   // half of the slot depending on the configured low time.
   assign sample_rd = (cmd_q == CMD_RD) && (cnt == RDS_AT) &&
                      ((state == SLOT_LOW) || (state == SLOT_HIGH));

   // Only a write of a 0 bit uses the long low time; reads use the short one.
   assign low_end = ((cmd_q == CMD_WR) && !shreg[bit_idx]) ? LOW0_END : LOW1_END;

`ifdef ONEWIRE_CRC8_EN
   logic       crc_ev;
   logic       crc_bit;
   logic [7:0] crc_next;

   // Reflected Dallas/Maxim CRC-8: shift right, fold 0x8C in on feedback.
   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[0] ^ b;
      crc_step = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
   endfunction

   // A write bit enters the CRC on the edge its slot is launched: bit 0 on
   // accept, later bits at the end of the previous recovery period.
   always_comb begin
      crc_ev  = 1'b0;
      crc_bit = 1'b0;
      if (state == IDLE && accept && cmd == CMD_WR) begin
         crc_ev  = 1'b1;
         crc_bit = tx_byte[0];
      end else if (state == SLOT_REC && cnt == REC_END && bit_idx != 3'd7 &&
                   cmd_q == CMD_WR) begin
         crc_ev  = 1'b1;
         crc_bit = shreg[bit_idx + 3'd1];
      end else if (sample_rd) begin
         crc_ev  = 1'b1;
         crc_bit = line_sync;
      end
   end

   always_comb begin
      crc_next = (crc_clear && cmd_ready) ? 8'h00 : crc;
      if (crc_ev) crc_next = crc_step(crc_next, crc_bit);
   end

   always_ff @(posedge clock) begin
      if (reset) crc <= 8'h00;
      else       crc <= crc_next;
   end
`endif

   // Idle bus floats high, so the synchroniser resets to 1.
   always_ff @(posedge clock) begin
      if (reset) sync <= 2'b11;
      else       sync <= {sync[0], line_in};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= 16'd0;
         bit_idx       <= 3'd0;
         cmd_q         <= 2'b11;
         shreg         <= 8'h00;
         cmd_ready     <= 1'b1;
         done          <= 1'b0;
         rx_byte       <= 8'h00;
         presence      <= 1'b0;
         line_pull_low <= 1'b0;
      end else begin
         done <= 1'b0;

         // Read data enters at the MSB; after eight slots bit 0 sits at [0].
         if (sample_rd) shreg <= {line_sync, shreg[7:1]};

         case (state)
            IDLE: begin
               if (accept) begin
                  cmd_q     <= cmd;
                  shreg     <= tx_byte;
                  cmd_ready <= 1'b0;
                  cnt       <= 16'd0;
                  bit_idx   <= 3'd0;
                  case (cmd)
                     CMD_RST: begin
                        state         <= RST_LOW;
                        line_pull_low <= 1'b1;
                     end
                     CMD_WR, CMD_RD: begin
                        state         <= SLOT_LOW;
                        line_pull_low <= 1'b1;
                     end
                     default: state <= FINISH;
                  endcase
               end
            end

            RST_LOW: begin
               cnt <= cnt + 16'd1;
               if (cnt == RSTL_END) begin
                  line_pull_low <= 1'b0;
                  cnt           <= 16'd0;
                  state         <= RST_HIGH;
               end
            end

            RST_HIGH: begin
               cnt <= cnt + 16'd1;
               if (cnt == PDS_AT) presence <= ~line_sync;
               if (cnt == RSTH_END) state <= FINISH;
            end

            // The counter runs on from SLOT_LOW into SLOT_HIGH so both the
            // read sample point and the slot end are relative to slot start.
            SLOT_LOW: begin
               cnt <= cnt + 16'd1;
               if (cnt == low_end) begin
                  line_pull_low <= 1'b0;
                  state         <= SLOT_HIGH;
               end
            end

            SLOT_HIGH: begin
               cnt <= cnt + 16'd1;
               if (cnt == SLOT_END) begin
                  cnt   <= 16'd0;
                  state <= SLOT_REC;
               end
            end

            SLOT_REC: begin
               cnt <= cnt + 16'd1;
               if (cnt == REC_END) begin
                  cnt <= 16'd0;
                  if (bit_idx == 3'd7) begin
                     state <= FINISH;
                  end else begin
                     bit_idx       <= bit_idx + 3'd1;
                     line_pull_low <= 1'b1;
                     state         <= SLOT_LOW;
                  end
               end
            end

            FINISH: begin
               done      <= 1'b1;
               cmd_ready <= 1'b1;
               if (cmd_q == CMD_RD) rx_byte <= shreg;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_onewire_slot_engine.sv
// ---------------------------------------------------------------------------
// tb_onewire_slot_engine
//
// Directed bench for onewire_slot_engine. Timing parameters are the nominal
// values divided by 100 so a full run stays short; all expected widths and
// latencies below are derived from those scaled values. A small open-drain
// slave model answers presence pulses and read slots.
// ---------------------------------------------------------------------------
module tb_onewire_slot_engine;

   localparam int T_RSTL = 480;
   localparam int T_PDS  = 70;
   localparam int T_RSTH = 480;
   localparam int T_SLOT = 65;
   localparam int T_LOW1 = 6;
   localparam int T_LOW0 = 60;
   localparam int T_RDS  = 15;
   localparam int T_REC  = 2;

   localparam int LAT_BYTE = 8 * (T_SLOT + T_REC) + 1;  // 537
   localparam int LAT_RST  = T_RSTL + T_RSTH + 1;       // 961

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic [1:0] cmd;
   logic [7:0] tx_byte;
   logic       cmd_ready;
   logic       done;
   logic [7:0] rx_byte;
   logic       presence;
   logic       line_in;
   logic       line_pull_low;
`ifdef ONEWIRE_CRC8_EN
   logic       crc_clear;
   logic [7:0] crc;
`endif

   always #5 clk = ~clk;

   onewire_slot_engine #(
      .T_RSTL(T_RSTL), .T_PDS(T_PDS), .T_RSTH(T_RSTH), .T_SLOT(T_SLOT),
      .T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_RDS(T_RDS), .T_REC(T_REC)
   ) dut (
      .clock(clk),
      .reset(rst),
      .cmd_valid(cmd_valid),
      .cmd(cmd),
      .tx_byte(tx_byte),
      .cmd_ready(cmd_ready),
      .done(done),
      .rx_byte(rx_byte),
      .presence(presence),
`ifdef ONEWIRE_CRC8_EN
      .crc_clear(crc_clear),
      .crc(crc),
`endif
      .line_in(line_in),
      .line_pull_low(line_pull_low)
   );

   // ---------------- slave model (open-drain wired-AND) ----------------
   int         slave_mode = 0;   // 0 none, 1 presence answer, 2 read data
   logic [7:0] rd_data = 8'h00;
   int         rise_cnt = 1000;
   int         fall_cnt = 1000;
   int         sbit = 0;
   logic       cur_bit = 1'b1;
   logic       lpl_d = 1'b0;
   logic       slave_low;

   initial forever begin
      @(posedge clk);
      lpl_d <= line_pull_low;
      if (line_pull_low && !lpl_d) begin
         rise_cnt <= 0;
         cur_bit  <= rd_data[sbit[2:0]];
         sbit     <= sbit + 1;
      end else if (rise_cnt < 1000) begin
         rise_cnt <= rise_cnt + 1;
      end
      if (!line_pull_low && lpl_d) fall_cnt <= 0;
      else if (fall_cnt < 1000)    fall_cnt <= fall_cnt + 1;
   end

   // Presence: low from 30 to 150 cycles after release. Read 0: hold low 30
   // cycles from slot start, well past the sample point.
   assign slave_low = (slave_mode == 1 && !line_pull_low && fall_cnt >= 30 && fall_cnt < 150) ||
                      (slave_mode == 2 && !cur_bit && rise_cnt < 30);
   assign line_in = ~line_pull_low & ~slave_low;

   // ---------------- line / done monitor ----------------
   int q_run = 0;
   int ncyc = 0;
   int done_cnt = 0;
   logic lpl_prev = 1'b0;
   int low_w[$];
   int rises[$];

   initial forever begin
      @(negedge clk);
      if (line_pull_low) q_run = q_run + 1;
      else if (q_run > 0) begin
         low_w.push_back(q_run);
         q_run = 0;
      end
      if (line_pull_low && !lpl_prev) rises.push_back(ncyc);
      lpl_prev = line_pull_low;
      if (done) done_cnt = done_cnt + 1;
      ncyc = ncyc + 1;
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic clear_mon();
      low_w.delete();
      rises.delete();
      done_cnt = 0;
   endtask

   // Present a command for one edge; returns positioned just after accept.
   task automatic issue(input logic [1:0] c, input logic [7:0] b);
      @(negedge clk);
      clear_mon();
      cmd_valid = 1'b1;
      cmd       = c;
      tx_byte   = b;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   // Edges from now until done is seen; -1 when the budget runs out.
   task automatic wait_done(input int budget, output int lat);
      int n;
      lat = -1;
      n = 0;
      while (n < budget && lat < 0) begin
         @(posedge clk);
         n = n + 1;
         @(negedge clk);
         if (done) lat = n;
      end
   endtask

   task automatic check_widths(input string tag, input logic [7:0] b);
      int w;
      chk({tag, "_nslots"}, low_w.size(), 8);
      for (int i = 0; i < 8; i++) begin
         w = (i < low_w.size()) ? low_w[i] : -1;
         chk($sformatf("%s_low%0d", tag, i), w, b[i] ? T_LOW1 : T_LOW0);
      end
   endtask

   int lat;
   int p;
   int per;

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd       = 2'b11;
      tx_byte   = 8'h00;
`ifdef ONEWIRE_CRC8_EN
      crc_clear = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_rx_byte", int'(rx_byte), 0);
      chk("rst_presence", int'(presence), 0);
      chk("rst_line_pull_low", int'(line_pull_low), 0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Bus reset with an answering slave
      slave_mode = 1;
      issue(2'b00, 8'h00);
      wait_done(LAT_RST + 50, lat);
      chk("busrst_latency", lat, LAT_RST);
      chk("busrst_npulse", low_w.size(), 1);
      chk("busrst_low_width", (low_w.size() > 0) ? low_w[0] : -1, T_RSTL);
      chk("busrst_presence", int'(presence), 1);
      repeat (5) @(negedge clk);
      chk("busrst_done_once", done_cnt, 1);
      chk("busrst_ready", int'(cmd_ready), 1);
      slave_mode = 0;

      // Read 0x3C, with stray cmd_valid pulses while busy
      rd_data    = 8'h3C;
      sbit       = 0;
      slave_mode = 2;
      issue(2'b10, 8'h00);
      chk("rd_ready_low", int'(cmd_ready), 0);
      p = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 cmd_valid = 1'b1;
         cmd = 2'b00;
         @(posedge clk);
         #1 cmd_valid = 1'b0;
         p = p + 2;
      end
      chk("rd_busy_ready", int'(cmd_ready), 0);
      wait_done(LAT_BYTE + 50, lat);
      chk("rd_latency", (lat < 0) ? -1 : lat + p, LAT_BYTE);
      chk("rd_rx_byte", int'(rx_byte), 8'h3C);
      repeat (5) @(negedge clk);
      chk("rd_done_once", done_cnt, 1);
      slave_mode = 0;

      // Bus reset, no slave: presence clears, rx_byte untouched
      issue(2'b00, 8'h00);
      wait_done(LAT_RST + 50, lat);
      chk("nosl_latency", lat, LAT_RST);
      chk("nosl_presence", int'(presence), 0);
      chk("nosl_rx_byte", int'(rx_byte), 8'h3C);

      // Write 0xA5: slot widths and slot+recovery period
      issue(2'b01, 8'hA5);
      wait_done(LAT_BYTE + 50, lat);
      chk("wrA5_latency", lat, LAT_BYTE);
      check_widths("wrA5", 8'hA5);
      chk("wrA5_nrises", rises.size(), 8);
      for (int i = 0; i < 7; i++) begin
         per = (i + 1 < rises.size()) ? rises[i+1] - rises[i] : -1;
         chk($sformatf("wrA5_period%0d", i), per, T_SLOT + T_REC);
      end
      chk("wrA5_rx_kept", int'(rx_byte), 8'h3C);
      repeat (5) @(negedge clk);
      chk("wrA5_done_once", done_cnt, 1);

      // No-op completes on the edge after accept
      issue(2'b11, 8'h00);
      wait_done(20, lat);
      chk("nop_latency", lat, 1);

      // Reset during bit 3 of a write
      issue(2'b01, 8'h5A);
      repeat (3 * (T_SLOT + T_REC) + 10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_line_pull_low", int'(line_pull_low), 0);
      chk("midrst_cmd_ready", int'(cmd_ready), 1);
      chk("midrst_done", int'(done), 0);
      chk("midrst_rx_byte", int'(rx_byte), 0);
      rst = 1'b0;
      repeat (LAT_BYTE) @(negedge clk);
      chk("midrst_no_done", done_cnt, 0);

      // Following write 0xFF completes normally
      issue(2'b01, 8'hFF);
      wait_done(LAT_BYTE + 50, lat);
      chk("wrFF_latency", lat, LAT_BYTE);
      check_widths("wrFF", 8'hFF);

`ifdef ONEWIRE_CRC8_EN
      @(negedge clk);
      crc_clear = 1'b1;
      @(negedge clk);
      crc_clear = 1'b0;
      chk("crc_cleared", int'(crc), 0);
      begin
         logic [7:0] rom [7];
         rom = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
         for (int i = 0; i < 7; i++) begin
            issue(2'b01, rom[i]);
            wait_done(LAT_BYTE + 50, lat);
         end
      end
      chk("crc_after_rom", int'(crc), 8'hA2);
      rd_data    = 8'hA2;
      sbit       = 0;
      slave_mode = 2;
      issue(2'b10, 8'h00);
      wait_done(LAT_BYTE + 50, lat);
      slave_mode = 0;
      chk("crc_rd_byte", int'(rx_byte), 8'hA2);
      chk("crc_final_zero", int'(crc), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
